// File: rtl/fire_sequencer.sv
// fire_sequencer
//   Safety sequencer for a capacitor-discharge firing circuit. It debounces the
//   arm and fire buttons and steps through SAFE -> CHARGE -> ARMED -> FIRE ->
//   DUMP. Any abort, loss of load continuity or timeout discharges the
//   capacitor. A charge timeout, or a DUMP that never reaches the safe voltage,
//   latches FAULT until reset.
//
// Configuration macro:
//   SEQ_PWM_EN - when defined, pwm in FIRE is duty-modulated by a free-running
//                3-bit counter against iset, which is latched on FIRE entry.
//                When undefined, pwm is solid 1 in FIRE and iset is unused.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   arm_button     in   raw arm button, active high
//   fire_button    in   raw fire button, active high
//   cont           in   load continuity present
//   lt3420_done    in   charger done
//   cap_volt       in   capacitor voltage ADC code (12 bit)
//   cap_volt_valid in   one-cycle strobe qualifying cap_volt
//   iset           in   fire duty setting (3 bit)
//   lt3420_charge  out  charger enable
//   pwm            out  fire switch drive
//   dump           out  discharge switch drive
//   arm_led        out  armed indicator
//   cont_led       out  continuity indicator (registered cont)
//   state          out  current state code (3 bit)
//   fault          out  sticky fault flag

module fire_sequencer #(
  parameter int unsigned DEBOUNCE       = 16,
  parameter logic [23:0] CHARGE_TIMEOUT = 24'd4800000,
  parameter logic [23:0] ARM_TIMEOUT    = 24'd14400000,
  parameter logic [23:0] FIRE_CYCLES    = 24'd48000,
  parameter logic [23:0] DUMP_MIN       = 24'd480000,
  parameter logic [11:0] V_TARGET       = 12'hC00,
  parameter logic [11:0] V_SAFE         = 12'h080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm_button,
  input  logic        fire_button,
  input  logic        cont,
  input  logic        lt3420_done,
  input  logic [11:0] cap_volt,
  input  logic        cap_volt_valid,
  input  logic [2:0]  iset,
  output logic        lt3420_charge,
  output logic        pwm,
  output logic        dump,
  output logic        arm_led,
  output logic        cont_led,
  output logic [2:0]  state,
  output logic        fault
);

  typedef enum logic [2:0] {
    StSafe   = 3'd0,
    StCharge = 3'd1,
    StArmed  = 3'd2,
    StFire   = 3'd3,
    StDump   = 3'd4,
    StFault  = 3'd5
  } state_e;

  // Debounce counter counts consecutive samples that disagree with the
  // accepted level; the DEBOUNCE-th such sample flips the level.
  localparam int unsigned   DbW    = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);

  // Limits compared against "cycles spent in state including this one", which
  // needs two extra bits for the 4x dump limit and for a saturated timer + 1.
  localparam logic [25:0] ChargeLimit = {2'b00, CHARGE_TIMEOUT};
  localparam logic [25:0] ArmLimit    = {2'b00, ARM_TIMEOUT};
  localparam logic [25:0] FireLimit   = {2'b00, FIRE_CYCLES};
  localparam logic [25:0] DumpMinLim  = {2'b00, DUMP_MIN};
  localparam logic [25:0] DumpMaxLim  = {DUMP_MIN, 2'b00};

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers; bit 0 = arm, bit 1 = fire
  // ---------------------------------------------------------------------------
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          level_q, level_d;
  logic [1:0]          press_q, press_d;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    level_d  = level_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
          // Only a 0->1 acceptance is a press.
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= {fire_button, arm_button};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  logic arm_press, fire_press;
  assign arm_press  = press_q[0];
  assign fire_press = press_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer state, timer and last-valid voltage
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [11:0] volt_q, volt_d;
  logic [25:0] elapsed;
  logic [11:0] volt_now;
  logic        volt_target_hit;

  // timer_q is 0 in the first cycle of a state, so elapsed is the number of
  // cycles spent in the state counting the current one.
  assign elapsed         = {2'b00, timer_q} + 26'd1;
  // A strobe arriving this cycle is the most recent valid reading.
  assign volt_now        = cap_volt_valid ? cap_volt : volt_q;
  assign volt_target_hit = cap_volt_valid && (cap_volt >= V_TARGET);
  assign volt_d          = volt_now;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSafe: begin
        if (arm_press && cont) state_d = StCharge;
      end
      StCharge: begin
        // Aborts win over completion so a dropped load never arms.
        if (!cont || arm_press) begin
          state_d = StDump;
        end else if (elapsed >= ChargeLimit) begin
          state_d = StFault;
        end else if (lt3420_done || volt_target_hit) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (!cont || arm_press || (elapsed >= ArmLimit)) begin
          state_d = StDump;
        end else if (fire_press) begin
          state_d = StFire;
        end
      end
      StFire: begin
        if (elapsed >= FireLimit) state_d = StDump;
      end
      StDump: begin
        if ((elapsed >= DumpMinLim) && (volt_now < V_SAFE)) begin
          state_d = StSafe;
        end else if (elapsed >= DumpMaxLim) begin
          state_d = StFault;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFault;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (&timer_q) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 24'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fire drive
  // ---------------------------------------------------------------------------
  logic pwm_d;

`ifdef SEQ_PWM_EN
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] iset_q, iset_d;

  always_comb begin
    cnt_d  = cnt_q + 3'd1;
    iset_d = iset_q;
    if ((state_d == StFire) && (state_q != StFire)) iset_d = iset;
    // Compare against the counter value that will be live with the output.
    pwm_d  = (state_d == StFire) && (cnt_d < iset_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      iset_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      iset_q <= iset_d;
    end
  end
`else
  logic unused_iset;
  assign unused_iset = ^iset;

  always_comb begin
    pwm_d = (state_d == StFire);
  end
`endif

  // ---------------------------------------------------------------------------
  // State register and registered Moore outputs (decoded from next state so
  // they change on the same edge as state)
  // ---------------------------------------------------------------------------
  logic charge_q, pwm_q, dump_q, arm_led_q, cont_led_q, fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StSafe;
      timer_q    <= '0;
      volt_q     <= 12'hFFF;
      charge_q   <= 1'b0;
      pwm_q      <= 1'b0;
      dump_q     <= 1'b1;
      arm_led_q  <= 1'b0;
      cont_led_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      volt_q     <= volt_d;
      charge_q   <= (state_d == StCharge);
      pwm_q      <= pwm_d;
      dump_q     <= (state_d == StSafe) || (state_d == StDump) || (state_d == StFault);
      arm_led_q  <= (state_d == StArmed) || (state_d == StFire);
      cont_led_q <= cont;
      fault_q    <= (state_d == StFault);
    end
  end

  assign lt3420_charge = charge_q;
  assign pwm           = pwm_q;
  assign dump          = dump_q;
  assign arm_led       = arm_led_q;
  assign cont_led      = cont_led_q;
  assign state         = state_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_fire_sequencer.sv
// tb_fire_sequencer
//   Self-checking bench for fire_sequencer. A behavioural model (delay line,
//   sample history, cycle stamps) predicts every output each cycle; directed
//   scenarios add explicit duration and boundary checks, then a randomized run
//   exercises the sequencer against the same model.

module tb_fire_sequencer;

  localparam int DEBOUNCE  = 4;
  localparam int CHARGE_TO = 100;
  localparam int ARM_TO    = 200;
  localparam int FIRE_N    = 10;
  localparam int DUMP_MIN  = 8;
  localparam int V_TARGET  = 'h800;
  localparam int V_SAFE    = 'h040;

  localparam int S_SAFE   = 0;
  localparam int S_CHARGE = 1;
  localparam int S_ARMED  = 2;
  localparam int S_FIRE   = 3;
  localparam int S_DUMP   = 4;
  localparam int S_FAULT  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm_button = 1'b0;
  logic        fire_button = 1'b0;
  logic        cont = 1'b1;
  logic        lt3420_done = 1'b0;
  logic [11:0] cap_volt = '0;
  logic        cap_volt_valid = 1'b0;
  logic [2:0]  iset = '0;
  logic        lt3420_charge, pwm, dump, arm_led, cont_led, fault;
  logic [2:0]  state;

  always #5 clk = ~clk;

  fire_sequencer #(
    .DEBOUNCE      (DEBOUNCE),
    .CHARGE_TIMEOUT(24'(CHARGE_TO)),
    .ARM_TIMEOUT   (24'(ARM_TO)),
    .FIRE_CYCLES   (24'(FIRE_N)),
    .DUMP_MIN      (24'(DUMP_MIN)),
    .V_TARGET      (12'(V_TARGET)),
    .V_SAFE        (12'(V_SAFE))
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .arm_button    (arm_button),
    .fire_button   (fire_button),
    .cont          (cont),
    .lt3420_done   (lt3420_done),
    .cap_volt      (cap_volt),
    .cap_volt_valid(cap_volt_valid),
    .iset          (iset),
    .lt3420_charge (lt3420_charge),
    .pwm           (pwm),
    .dump          (dump),
    .arm_led       (arm_led),
    .cont_led      (cont_led),
    .state         (state),
    .fault         (fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int        m_state, m_entry, m_now, m_edges;
  bit [11:0] m_volt;
  bit [2:0]  m_iset;
  bit        m_cont_led;
  bit        m_lvl   [2];
  bit        m_press [2];
  bit        m_dl    [2][2];
  bit        m_hist  [2][DEBOUNCE];

  function automatic void model_reset();
    m_state    = S_SAFE;
    m_entry    = m_now;
    m_edges    = 0;
    m_volt     = 12'hFFF;
    m_iset     = '0;
    m_cont_led = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b]   = 1'b0;
      m_press[b] = 1'b0;
      m_dl[b][0] = 1'b0;
      m_dl[b][1] = 1'b0;
      for (int i = 0; i < DEBOUNCE; i++) m_hist[b][i] = 1'b0;
    end
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    int        nxt, spent;
    bit [11:0] last_v;
    bit        raw [2];
    bit        smp, flip;
    m_now++;
    if (reset) begin
      model_reset();
      return;
    end
    spent  = m_now - m_entry;
    last_v = cap_volt_valid ? cap_volt : m_volt;
    nxt    = m_state;
    case (m_state)
      S_SAFE:   if (m_press[0] && cont) nxt = S_CHARGE;
      S_CHARGE: begin
        if (!cont || m_press[0]) nxt = S_DUMP;
        else if (spent >= CHARGE_TO) nxt = S_FAULT;
        else if (lt3420_done || (cap_volt_valid && int'(cap_volt) >= V_TARGET)) nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!cont || m_press[0] || spent >= ARM_TO) nxt = S_DUMP;
        else if (m_press[1]) nxt = S_FIRE;
      end
      S_FIRE:   if (spent >= FIRE_N) nxt = S_DUMP;
      S_DUMP: begin
        if (spent >= DUMP_MIN && int'(last_v) < V_SAFE) nxt = S_SAFE;
        else if (spent >= 4 * DUMP_MIN) nxt = S_FAULT;
      end
      default:  nxt = S_FAULT;
    endcase
    if (cap_volt_valid) m_volt = cap_volt;
    if (nxt != m_state) begin
      m_entry = m_now;
      if (nxt == S_FIRE) m_iset = iset;
    end
    m_state    = nxt;
    m_cont_led = cont;
    m_edges++;
    raw[0] = arm_button;
    raw[1] = fire_button;
    for (int b = 0; b < 2; b++) begin
      smp        = m_dl[b][0];
      m_dl[b][0] = m_dl[b][1];
      m_dl[b][1] = raw[b];
      for (int i = DEBOUNCE - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = smp;
      flip = 1'b1;
      for (int i = 0; i < DEBOUNCE; i++) if (m_hist[b][i] == m_lvl[b]) flip = 1'b0;
      m_press[b] = 1'b0;
      if (flip) begin
        m_lvl[b]   = ~m_lvl[b];
        m_press[b] = m_lvl[b];
      end
    end
  endfunction

  function automatic bit exp_pwm();
`ifdef SEQ_PWM_EN
    return (m_state == S_FIRE) && ((m_edges % 8) < int'(m_iset));
`else
    return m_state == S_FIRE;
`endif
  endfunction

  // One clock: model the edge, then compare every output half a cycle later.
  task automatic tick();
    model_edge();
    @(negedge clk);
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("lt3420_charge", 32'(lt3420_charge), 32'(m_state == S_CHARGE));
    check_eq("dump", 32'(dump),
             32'(m_state == S_SAFE || m_state == S_DUMP || m_state == S_FAULT));
    check_eq("arm_led", 32'(arm_led), 32'(m_state == S_ARMED || m_state == S_FIRE));
    check_eq("fault", 32'(fault), 32'(m_state == S_FAULT));
    check_eq("cont_led", 32'(cont_led), 32'(m_cont_led));
    check_eq("pwm", 32'(pwm), 32'(exp_pwm()));
    check_eq("pwm_dump_excl", 32'(pwm & dump), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    arm_button     = 1'b0;
    fire_button    = 1'b0;
    lt3420_done    = 1'b0;
    cap_volt_valid = 1'b0;
    cont           = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int s, input int bound);
    int n = 0;
    while (state !== 3'(s) && n < bound) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  // Counts consecutive observations of state s (starting now) and pwm highs.
  task automatic count_state(input int s, input int bound, output int n, output int p);
    n = 0;
    p = 0;
    while (state === 3'(s) && n < bound) begin
      n++;
      p += int'(pwm);
      tick();
    end
  endtask

  task automatic reach_armed();
    do_reset();
    arm_button = 1'b1;
    wait_state("to_charge", S_CHARGE, 12);
    arm_button  = 1'b0;
    lt3420_done = 1'b1;
    tick();
    lt3420_done = 1'b0;
    check_eq("to_armed", 32'(state), S_ARMED);
  endtask

  initial begin
    int n, p, arm_run, fire_run;

    // Reset state
    do_reset();
    check_eq("rst_state", 32'(state), S_SAFE);
    check_eq("rst_dump", 32'(dump), 1);
    check_eq("rst_pwm", 32'(pwm), 0);
    check_eq("rst_fault", 32'(fault), 0);

    // Full sequence
    hold_seq : begin
      arm_button = 1'b1;
      run(8);
      arm_button = 1'b0;
      check_eq("seq_charge_state", 32'(state), S_CHARGE);
      check_eq("seq_charge_out", 32'(lt3420_charge), 1);
      cap_volt       = 12'h900;
      cap_volt_valid = 1'b1;
      tick();
      cap_volt_valid = 1'b0;
      check_eq("seq_armed", 32'(state), S_ARMED);
      fire_button = 1'b1;
      wait_state("seq_fire_entry", S_FIRE, 12);
      fire_button = 1'b0;
      count_state(S_FIRE, 20, n, p);
      check_eq("seq_fire_len", 32'(n), FIRE_N);
      check_eq("seq_pwm_cycles", 32'(p), FIRE_N);
      check_eq("seq_dump_entry", 32'(state), S_DUMP);
      cap_volt       = 12'h010;
      cap_volt_valid = 1'b1;
      tick();
      cap_volt_valid = 1'b0;
      count_state(S_DUMP, 40, n, p);
      check_eq("seq_dump_len", 32'(n + 1), DUMP_MIN);
      check_eq("seq_safe", 32'(state), S_SAFE);
    end

    // Bounce: 3-cycle pulses never accepted
    do_reset();
    for (int r = 0; r < 5; r++) begin
      arm_button = 1'b1;
      run(3);
      arm_button = 1'b0;
      run(3);
    end
    run(6);
    check_eq("bounce_safe", 32'(state), S_SAFE);

    // Charge timeout
    do_reset();
    arm_button = 1'b1;
    wait_state("chg_entry", S_CHARGE, 12);
    arm_button = 1'b0;
    count_state(S_CHARGE, 150, n, p);
    check_eq("chg_to_len", 32'(n), CHARGE_TO);
    check_eq("chg_to_state", 32'(state), S_FAULT);
    check_eq("chg_to_dump", 32'(dump), 1);
    check_eq("chg_to_fault", 32'(fault), 1);
    run(40);
    check_eq("fault_sticky", 32'(state), S_FAULT);
    do_reset();
    check_eq("fault_cleared", 32'(fault), 0);

    // Simultaneous arm and fire press in ARMED
    reach_armed();
    run(6);
    arm_button  = 1'b1;
    fire_button = 1'b1;
    p = 0;
    n = 0;
    while (state !== 3'(S_DUMP) && n < 12) begin
      tick();
      p += int'(pwm);
      n++;
    end
    arm_button  = 1'b0;
    fire_button = 1'b0;
    check_eq("both_dump", 32'(state), S_DUMP);
    check_eq("both_no_pwm", 32'(p), 0);

    // Continuity loss in ARMED
    reach_armed();
    run(3);
    cont = 1'b0;
    tick();
    cont = 1'b1;
    check_eq("cont_drop_dump", 32'(state), S_DUMP);

    // ARMED timeout
    reach_armed();
    count_state(S_ARMED, 250, n, p);
    check_eq("arm_to_len", 32'(n), ARM_TO);
    check_eq("arm_to_dump", 32'(state), S_DUMP);

    // Reset mid-FIRE
    reach_armed();
    run(6);
    iset        = 3'd3;
    fire_button = 1'b1;
    wait_state("rst_fire_entry", S_FIRE, 12);
    fire_button = 1'b0;
    run(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_fire_pwm", 32'(pwm), 0);
    check_eq("rst_fire_dump", 32'(dump), 1);
    check_eq("rst_fire_state", 32'(state), S_SAFE);

`ifdef SEQ_PWM_EN
    // Duty 3/8 with iset = 3
    reach_armed();
    run(6);
    iset        = 3'd3;
    fire_button = 1'b1;
    wait_state("duty_fire_entry", S_FIRE, 12);
    fire_button = 1'b0;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      p += int'(pwm);
      tick();
    end
    check_eq("duty_3_of_8", 32'(p), 3);
`endif

    // Randomized run against the model
    do_reset();
    arm_run  = 0;
    fire_run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (arm_run == 0) begin
        arm_button = ($urandom_range(0, 3) == 0);
        arm_run    = int'($urandom_range(1, 10));
      end
      arm_run--;
      if (fire_run == 0) begin
        fire_button = ($urandom_range(0, 4) < 2);
        fire_run    = int'($urandom_range(1, 10));
      end
      fire_run--;
      cont           = ($urandom_range(0, 99) != 0);
      lt3420_done    = ($urandom_range(0, 29) == 0);
      cap_volt_valid = ($urandom_range(0, 5) == 0);
      cap_volt       = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 'h7f))
                                                   : 12'($urandom_range('h700, 'hfff));
      iset           = 3'($urandom);
      reset          = (m_state == S_FAULT) ? ($urandom_range(0, 19) == 0)
                                            : ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
